// File: rtl/complex_mult_fx_seq_if.sv
// Operand/result handshake bundle for complex_mult_fx_seq.
// master drives operands and out_ack; slave (the multiplier) drives in_ack and the result.
interface complex_mult_fx_seq_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] a_re;
    logic signed [WIDTH-1:0] a_im;
    logic signed [WIDTH-1:0] b_re;
    logic signed [WIDTH-1:0] b_im;
    logic                    conj_b;
    logic                    in_stb;
    logic                    in_ack;
    logic signed [WIDTH-1:0] z_re;
    logic signed [WIDTH-1:0] z_im;
    logic                    ovf;
    logic                    out_stb;
    logic                    out_ack;

    modport master (
        output a_re, a_im, b_re, b_im, conj_b, in_stb, out_ack,
        input  in_ack, z_re, z_im, ovf, out_stb
    );

    modport slave (
        input  a_re, a_im, b_re, b_im, conj_b, in_stb, out_ack,
        output in_ack, z_re, z_im, ovf, out_stb
    );
endinterface

// File: rtl/complex_mult_fx_seq.sv
// Sequential fixed-point complex multiplier, z = a*b or a*conj(b), one shared multiplier.
// CMUL_SAT_EN: overflowing result parts saturate instead of wrapping.
//
//   state | meaning
//   GET   | in_ack high, waiting for an operand set
//   MUL   | four partial products accumulated, cnt 0..3
//   SUM   | round, scale, range-check, register result
//   PUT   | out_stb high, result held until out_ack
module complex_mult_fx_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    complex_mult_fx_seq_if.slave   bus
);
    localparam int PW     = 2 * WIDTH;
    localparam int AW     = 2 * WIDTH + 1;
    localparam int RW     = AW + 1;
    localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic signed [RW-1:0] RND = (FRAC > 0) ? (RW'(1) << RND_SH) : '0;
    localparam logic [WIDTH-1:0] Z_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Z_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {GET, MUL, SUM, PUT} state_t;

    state_t                  state;
    logic [1:0]              cnt;
    logic signed [WIDTH-1:0] ar, ai, br, bi;
    logic                    cj;
    logic signed [AW-1:0]    acc_re, acc_im;

    logic signed [WIDTH-1:0] mul_x, mul_y;
    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    prod_ext;
    logic signed [RW-1:0]    r_re, r_im;
    logic                    fit_re, fit_im;
    logic [WIDTH-1:0]        zn_re, zn_im;

    // Partial product order: ar*br, ai*bi, ar*bi, ai*br
    always_comb begin
        mul_x = ar;
        mul_y = br;
        case (cnt)
            2'd1:    begin mul_x = ai; mul_y = bi; end
            2'd2:    begin mul_x = ar; mul_y = bi; end
            2'd3:    begin mul_x = ai; mul_y = br; end
            default: begin mul_x = ar; mul_y = br; end
        endcase
    end

    assign prod     = PW'(mul_x) * PW'(mul_y);
    assign prod_ext = AW'(prod);

    always_comb begin
        r_re   = (RW'(acc_re) + RND) >>> FRAC;
        r_im   = (RW'(acc_im) + RND) >>> FRAC;
        // A part fits when everything above the result sign bit is sign extension
        fit_re = (&r_re[RW-1:WIDTH-1]) | ~(|r_re[RW-1:WIDTH-1]);
        fit_im = (&r_im[RW-1:WIDTH-1]) | ~(|r_im[RW-1:WIDTH-1]);
`ifdef CMUL_SAT_EN
        zn_re  = fit_re ? r_re[WIDTH-1:0] : (r_re[RW-1] ? Z_MIN : Z_MAX);
        zn_im  = fit_im ? r_im[WIDTH-1:0] : (r_im[RW-1] ? Z_MIN : Z_MAX);
`else
        zn_re  = r_re[WIDTH-1:0];
        zn_im  = r_im[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= GET;
            cnt         <= '0;
            ar          <= '0;
            ai          <= '0;
            br          <= '0;
            bi          <= '0;
            cj          <= 1'b0;
            acc_re      <= '0;
            acc_im      <= '0;
            bus.in_ack  <= 1'b0;
            bus.out_stb <= 1'b0;
            bus.z_re    <= '0;
            bus.z_im    <= '0;
            bus.ovf     <= 1'b0;
        end else begin
            case (state)
                GET: begin
                    if (bus.in_stb && bus.in_ack) begin
                        ar         <= bus.a_re;
                        ai         <= bus.a_im;
                        br         <= bus.b_re;
                        bi         <= bus.b_im;
                        cj         <= bus.conj_b;
                        acc_re     <= '0;
                        acc_im     <= '0;
                        cnt        <= '0;
                        bus.in_ack <= 1'b0;
                        state      <= MUL;
                    end else begin
                        bus.in_ack <= 1'b1;
                    end
                end
                MUL: begin
                    case (cnt)
                        2'd0:    acc_re <= acc_re + prod_ext;
                        2'd1:    acc_re <= cj ? acc_re + prod_ext : acc_re - prod_ext;
                        2'd2:    acc_im <= cj ? acc_im - prod_ext : acc_im + prod_ext;
                        default: acc_im <= acc_im + prod_ext;
                    endcase
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3)
                        state <= SUM;
                end
                SUM: begin
                    bus.z_re    <= zn_re;
                    bus.z_im    <= zn_im;
                    bus.ovf     <= ~(fit_re & fit_im);
                    bus.out_stb <= 1'b1;
                    state       <= PUT;
                end
                PUT: begin
                    if (bus.out_ack) begin
                        bus.out_stb <= 1'b0;
                        state       <= GET;
                    end
                end
                default: state <= GET;
            endcase
        end
    end
endmodule

// File: tb/tb_complex_mult_fx_seq.sv
// Self-checking bench for complex_mult_fx_seq: directed vector table, random ops
// against an arithmetic reference model, backpressure and mid-op reset sequences.
module tb_complex_mult_fx_seq;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam longint LIM = longint'(1) <<< (WIDTH - 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    complex_mult_fx_seq_if #(.WIDTH(WIDTH)) bus ();
    complex_mult_fx_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int ar, ai, br, bi;
        bit cj;
        int zr, zi;
        bit ov;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[7];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit in_range(input longint r);
        return (r >= -LIM) && (r <= LIM - 1);
    endfunction

    function automatic int limit(input longint r);
        logic signed [WIDTH-1:0] w;
        if (in_range(r))
            return int'(r);
`ifdef CMUL_SAT_EN
        return (r < 0) ? int'(-LIM) : int'(LIM - 1);
`else
        w = r[WIDTH-1:0];
        return int'(w);
`endif
    endfunction

    // Exact complex product, then round-half-up scaling by 2^FRAC
    function automatic vec_t model(input vec_t v);
        longint re, im, rr, ri;
        vec_t   o;
        o  = v;
        re = v.cj ? longint'(v.ar) * v.br + longint'(v.ai) * v.bi
                  : longint'(v.ar) * v.br - longint'(v.ai) * v.bi;
        im = v.cj ? longint'(v.ai) * v.br - longint'(v.ar) * v.bi
                  : longint'(v.ar) * v.bi + longint'(v.ai) * v.br;
        rr = (re + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        ri = (im + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        o.ov = !(in_range(rr) && in_range(ri));
        o.zr = limit(rr);
        o.zi = limit(ri);
        return o;
    endfunction

    task automatic scramble();
        bus.a_re   = WIDTH'($urandom);
        bus.a_im   = WIDTH'($urandom);
        bus.b_re   = WIDTH'($urandom);
        bus.b_im   = WIDTH'($urandom);
        bus.conj_b = 1'($urandom);
    endtask

    task automatic run_op(input vec_t v, input int hold, input string name);
        int n, lat;
        logic signed [WIDTH-1:0] zr0, zi0;
        logic ov0;
        bit stable;
        bus.a_re   = WIDTH'(v.ar);
        bus.a_im   = WIDTH'(v.ai);
        bus.b_re   = WIDTH'(v.br);
        bus.b_im   = WIDTH'(v.bi);
        bus.conj_b = v.cj;
        bus.in_stb = 1'b1;
        n = 0;
        while (!bus.in_ack && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " in_ack"}, bus.in_ack, 1);
        @(posedge clk); #1;
        bus.in_stb = 1'b0;
        scramble();
        lat = 0;
        while (!bus.out_stb && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, 5);
        check({name, " z_re"}, int'(bus.z_re), v.zr);
        check({name, " z_im"}, int'(bus.z_im), v.zi);
        check({name, " ovf"}, bus.ovf, v.ov);
        if (hold > 0) begin
            zr0 = bus.z_re; zi0 = bus.z_im; ov0 = bus.ovf;
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (bus.z_re !== zr0 || bus.z_im !== zi0 || bus.ovf !== ov0 ||
                    bus.out_stb !== 1'b1 || bus.in_ack !== 1'b0)
                    stable = 1'b0;
            end
            check({name, " hold stable"}, stable, 1);
        end
        bus.out_ack = 1'b1;
        @(posedge clk); #1;
        bus.out_ack = 1'b0;
        check({name, " out_stb after ack"}, bus.out_stb, 0);
        check({name, " in_ack on ack edge"}, bus.in_ack, 0);
        @(posedge clk); #1;
        check({name, " in_ack after ack"}, bus.in_ack, 1);
    endtask

    initial begin
        vec_t v;
        bit   rose;

        tbl[0] = '{ar: 256,    ai: 512, br: 768, bi: 1024, cj: 0, zr: -1280, zi: 2560, ov: 0};
        tbl[1] = '{ar: 256,    ai: 512, br: 768, bi: 1024, cj: 1, zr: 2816,  zi: 512,  ov: 0};
        tbl[2] = '{ar: 1,      ai: 0,   br: 128, bi: 0,    cj: 0, zr: 1,     zi: 0,    ov: 0};
        tbl[3] = '{ar: -1,     ai: 0,   br: 128, bi: 0,    cj: 0, zr: 0,     zi: 0,    ov: 0};
`ifdef CMUL_SAT_EN
        tbl[4] = '{ar: 32512,  ai: 0,   br: 512, bi: 0,    cj: 0, zr: 32767, zi: 0,    ov: 1};
        tbl[5] = '{ar: -32768, ai: 0,   br: 512, bi: 0,    cj: 0, zr: -32768, zi: 0,   ov: 1};
`else
        tbl[4] = '{ar: 32512,  ai: 0,   br: 512, bi: 0,    cj: 0, zr: -512,  zi: 0,    ov: 1};
        tbl[5] = '{ar: -32768, ai: 0,   br: 512, bi: 0,    cj: 0, zr: 0,     zi: 0,    ov: 1};
`endif
        tbl[6] = '{ar: 0,      ai: 256, br: 0,   bi: 256,  cj: 1, zr: 256,   zi: 0,    ov: 0};

        bus.in_stb  = 1'b0;
        bus.out_ack = 1'b0;
        scramble();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ack", bus.in_ack, 0);
        check("reset out_stb", bus.out_stb, 0);
        check("reset z_re", int'(bus.z_re), 0);
        check("reset z_im", int'(bus.z_im), 0);
        check("reset ovf", bus.ovf, 0);
        rst = 1'b1;
        #1;
        check("in_ack before first edge", bus.in_ack, 0);
        @(posedge clk); #1;
        check("in_ack after release", bus.in_ack, 1);

        // Stray out_ack while idle must not disturb anything
        bus.out_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ack = 1'b0;
        check("idle out_ack ignored", bus.out_stb, 0);

        for (int i = 0; i < 7; i++)
            run_op(tbl[i], 0, $sformatf("vec%0d", i));

        run_op(tbl[0], 20, "backpressure");

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                v.ar = int'($urandom_range(0, 1023)) - 512;
                v.ai = int'($urandom_range(0, 1023)) - 512;
                v.br = int'($urandom_range(0, 1023)) - 512;
                v.bi = int'($urandom_range(0, 1023)) - 512;
            end else begin
                v.ar = int'($urandom_range(0, 65535)) - 32768;
                v.ai = int'($urandom_range(0, 65535)) - 32768;
                v.br = int'($urandom_range(0, 65535)) - 32768;
                v.bi = int'($urandom_range(0, 65535)) - 32768;
            end
            v.cj = 1'($urandom);
            v = model(v);
            run_op(v, 0, $sformatf("rand%0d", i));
        end

        // Reset during MUL: op discarded, outputs back to reset values at once
        bus.a_re = WIDTH'(tbl[4].ar); bus.a_im = WIDTH'(tbl[4].ai);
        bus.b_re = WIDTH'(tbl[4].br); bus.b_im = WIDTH'(tbl[4].bi);
        bus.conj_b = 1'b0;
        bus.in_stb = 1'b1;
        @(posedge clk); #1;
        bus.in_stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midop rst in_ack", bus.in_ack, 0);
        check("midop rst out_stb", bus.out_stb, 0);
        check("midop rst z_re", int'(bus.z_re), 0);
        check("midop rst ovf", bus.ovf, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        rose = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_stb) rose = 1'b1;
        end
        check("midop rst out_stb never rises", rose, 0);
        check("midop rst in_ack restored", bus.in_ack, 1);
        run_op(tbl[1], 0, "after midop rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
